operand_bank_loader: RTL
========================

# operand_bank_loader

Serial-in, ping-pong operand loader that produces the two interleaved 8-bit operand banks consumed by the second-stage 2:1 operand multiplexer of the modular adder/subtractor. Operand bits arrive one per accepted handshake into the hidden (shadow) bank while the multiplexer reads the visible bank. When a full frame is loaded and the consumer has released the previous one, the loader flips the bank select. It is the writer side of the mux's select/bank interface.

## Interface
- BANK_W, 8, bits per bank; fixed at 8 for the current operand format. Bit map per bank: [7]=b4, [6]=a3, [5]=b3, [4]=a2, [3]=b2, [2]=a1, [1]=b1, [0]=a0.
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  loader accepts a bit this cycle.
- in_bit  input  1  serial operand bit, MSB (b4) first.
- abort  input  1  synchronous discard of the partially loaded shadow frame.
- out_ack  input  1  consumer has finished with the visible bank.
- sel  output  1  bank select to the mux: 0 selects bank0, 1 selects bank1.
- bank0  output  8  bank 0 contents (mux "_0" inputs).
- bank1  output  8  bank 1 contents (mux "_1" inputs).
- out_valid  output  1  visible bank holds an unacknowledged frame.

## Operation
- Registers: bank0, bank1, sel, cnt (3 bit), state {LOAD, FULL}, out_valid.
- Reset values: bank0=8'h00, bank1=8'h00, sel=0, cnt=0, state=LOAD, out_valid=0, so in_ready=1.
- The shadow bank is bank1 when sel=0 and bank0 when sel=1. The visible bank (bank[sel]) is never written.
- in_ready = (state==LOAD) and not abort.
- Accept = in_valid & in_ready. On accept: shadow <= {shadow[6:0], in_bit}, and cnt <= cnt+1 (wraps 7->0).
- LOAD->FULL: on the accept that happens while cnt==7.
- FULL: in_ready=0, and in_valid is ignored. Swap condition is (!out_valid | out_ack).
- On swap: sel <= ~sel, out_valid <= 1, cnt <= 0, state <= LOAD.
- out_ack with out_valid=1 and no swap in that cycle: out_valid <= 0.
- Swap and out_ack in the same cycle: the swap wins, so out_valid stays 1 (the new frame is pending).
- out_ack while out_valid=0: no effect.
- abort in LOAD: cnt <= 0, and the bit on in_bit is not accepted. The shadow contents are left stale; they are fully overwritten by the next 8 accepts.
- abort in FULL: ignored. The completed frame still swaps.
- abort never touches sel, out_valid or the visible bank.
- rst_n low at any time, including mid-frame or in FULL: all registers return to their reset values immediately.

## Timing
- Frame load takes 8 accepts, with arbitrary in_valid gaps between them.
- Swap occurs at the earliest on the clock edge after the 8th accept (FULL lasts at least 1 cycle).
- sel, out_valid and both banks are registered outputs; the mux sees the new sel one cycle after the 8th accept.
- Peak throughput is 9 cycles per frame with continuous in_valid and no backpressure.
- Backpressure: FULL persists until out_ack. Swap happens on the edge of the out_ack cycle, and in_ready returns to 1 in the following cycle.
- No combinational path from in_valid or in_bit to any output. in_ready depends combinationally only on state and abort.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: sel=0, bank0=bank1=8'h00, out_valid=0, in_ready=1.
- First frame: stream 8'hB2 MSB-first with in_valid held high.
  - After the 8th accept: bank1=8'hB2, in_ready=0.
  - Next cycle: sel=1, out_valid=1, in_ready=1, bank0 still 8'h00.
- Backpressure:
  - Without acking, stream 8'h5C. Required: it loads into bank0, then FULL holds with in_ready=0 and sel=1 for 5 idle cycles.
  - Pulse out_ack. Required: swap on that edge, sel=0, out_valid stays 1, bank1 unchanged at 8'hB2.
- Gapped input: send 8'hA5 with in_valid low for 2 cycles between each bit. Required: the shadow bank equals 8'hA5 and the swap occurs exactly one cycle after the 8th accept.
- Abort: send 3 bits, assert abort for 1 cycle, then send 8'hFF.
  - Required: no swap after only 5 total accepts following the abort.
  - Swap after the 8th post-abort accept, with shadow=8'hFF.
  - abort asserted during FULL: the swap still occurs.
- Reset mid-frame: assert rst_n=0 after 5 bits of a frame, asynchronously between edges. Required: outputs take their reset values immediately. After release, a fresh 8'h3C loads into bank1 with sel=0 beforehand.

Source files
------------

// File: rtl/operand_bank_loader_if.sv
// Handshake and bank bus between the serial operand source, the loader
// and the second-stage operand multiplexer.
`timescale 1ns/1ps

interface operand_bank_loader_if #(
  parameter int BANK_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_bit;
  logic              abort;
  logic              out_ack;
  logic              sel;
  logic [BANK_W-1:0] bank0;
  logic [BANK_W-1:0] bank1;
  logic              out_valid;

  // Source/consumer side: drives the bit stream and the release of the visible bank
  modport master (
    output in_valid, in_bit, abort, out_ack,
    input  in_ready, sel, bank0, bank1, out_valid
  );

  // Loader side: owns the banks and the bank select
  modport slave (
    input  in_valid, in_bit, abort, out_ack,
    output in_ready, sel, bank0, bank1, out_valid
  );
endinterface

// File: rtl/operand_bank_loader.sv
// Ping-pong serial operand loader. Bits are shifted MSB-first into the
// hidden bank while the mux reads the visible one; a completed frame is
// published by flipping sel once the consumer has released the old frame.
`timescale 1ns/1ps

module operand_bank_loader (
  input logic                 clk,
  input logic                 rst_n,
  operand_bank_loader_if.slave bus
);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       sel, sel_n;
  logic       out_valid, out_valid_n;
  logic [7:0] bank0, bank0_n;
  logic [7:0] bank1, bank1_n;
  logic       in_ready;
  logic       accept;
  logic       swap;

  // A full frame waits in FULL; abort only blocks acceptance while loading
  assign in_ready = (state == LOAD) && !bus.abort;
  assign accept   = bus.in_valid && in_ready;
  assign swap     = (state == FULL) && (!out_valid || bus.out_ack);

  assign bus.in_ready  = in_ready;
  assign bus.sel       = sel;
  assign bus.bank0     = bank0;
  assign bus.bank1     = bank1;
  assign bus.out_valid = out_valid;

  // Next-state logic: shift into the shadow bank, detect frame end, publish on swap
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel_n       = sel;
    out_valid_n = out_valid;
    bank0_n     = bank0;
    bank1_n     = bank1;

    case (state)
      LOAD: begin
        if (bus.abort) begin
          cnt_n = 3'd0;
        end else if (accept) begin
          if (sel) begin
            bank0_n = {bank0[6:0], bus.in_bit};
          end else begin
            bank1_n = {bank1[6:0], bus.in_bit};
          end
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_n = FULL;
          end
        end
      end
      FULL: begin
        if (swap) begin
          sel_n       = ~sel;
          out_valid_n = 1'b1;
          cnt_n       = 3'd0;
          state_n     = LOAD;
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase

    // A release without a simultaneous swap retires the visible frame;
    // when both happen, the freshly published frame keeps out_valid high.
    if (bus.out_ack && out_valid && !swap) begin
      out_valid_n = 1'b0;
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= 3'd0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      bank0     <= 8'h00;
      bank1     <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sel       <= sel_n;
      out_valid <= out_valid_n;
      bank0     <= bank0_n;
      bank1     <= bank1_n;
    end
  end

endmodule
